// File: rtl/ppe_w1024_p.sv
// Two-stage pipelined programmable priority encoder over a wide request vector.
// Searches upward from P_enc and wraps to index 0 when nothing is found at or above it.
module ppe_w1024_p #(
  parameter int WIDTH = 1024,
  parameter int IDX_W = 10,
  parameter int GRP   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Req,
  input  logic [IDX_W-1:0] P_enc,
  output logic [IDX_W-1:0] o_value,
  output logic [IDX_W-1:0] o_value_inc,
  output logic             valid
);

  localparam int NG  = WIDTH / GRP;
  localparam int GW  = $clog2(GRP);
  localparam int NGW = $clog2(NG);

  logic [WIDTH-1:0]       masked;
  logic [NG-1:0]          m_any_c, u_any_c;
  logic [NG-1:0][GW-1:0]  m_idx_c, u_idx_c;

  logic [NG-1:0]          s1_m_any, s1_u_any;
  logic [NG-1:0][GW-1:0]  s1_m_idx, s1_u_idx;

  logic [NGW-1:0]         m_grp, u_grp;
  logic                   m_hit, u_hit;
  logic [IDX_W-1:0]       nxt_value;

  always_comb begin
    masked = '0;
    for (int i = 0; i < WIDTH; i++) begin
      masked[i] = Req[i] && (IDX_W'(i) >= P_enc);
    end
  end

  // Per-group first-one: scanning downward lets the lowest set bit win.
  always_comb begin
    m_any_c = '0;
    u_any_c = '0;
    m_idx_c = '0;
    u_idx_c = '0;
    for (int g = 0; g < NG; g++) begin
      m_any_c[g] = |masked[g*GRP +: GRP];
      u_any_c[g] = |Req[g*GRP +: GRP];
      for (int j = GRP - 1; j >= 0; j--) begin
        if (masked[g*GRP + j]) m_idx_c[g] = GW'(j);
        if (Req[g*GRP + j])    u_idx_c[g] = GW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_m_any <= '0;
      s1_u_any <= '0;
      s1_m_idx <= '0;
      s1_u_idx <= '0;
    end else begin
      s1_m_any <= m_any_c;
      s1_u_any <= u_any_c;
      s1_m_idx <= m_idx_c;
      s1_u_idx <= u_idx_c;
    end
  end

  always_comb begin
    m_grp     = '0;
    u_grp     = '0;
    m_hit     = |s1_m_any;
    u_hit     = |s1_u_any;
    nxt_value = '0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (s1_m_any[g]) m_grp = NGW'(g);
      if (s1_u_any[g]) u_grp = NGW'(g);
    end
    // The masked hit takes precedence; the unmasked search is the wrap-around fallback.
    if (m_hit)      nxt_value = {m_grp, s1_m_idx[m_grp]};
    else if (u_hit) nxt_value = {u_grp, s1_u_idx[u_grp]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_value     <= '0;
      o_value_inc <= '0;
      valid       <= 1'b0;
    end else begin
      o_value     <= nxt_value;
      o_value_inc <= u_hit ? nxt_value + IDX_W'(1) : '0;
      valid       <= u_hit;
    end
  end

endmodule

// File: tb/tb_ppe_w1024_p.sv
// Bench for ppe_w1024_p: directed vector table, reset corner sequences and random traffic,
// with expected results queued at drive time and compared when they leave the pipeline.
module tb_ppe_w1024_p;

  typedef struct {
    logic [1023:0] req;
    logic [9:0]    p;
    logic [9:0]    ev;
    logic [9:0]    ei;
    logic          evld;
  } vec_t;

  typedef struct {
    logic [9:0] ev;
    logic [9:0] ei;
    logic       evld;
    int         tag;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [1023:0] Req;
  logic [9:0]    P_enc;
  logic [9:0]    o_value;
  logic [9:0]    o_value_inc;
  logic          valid;

  int   total;
  int   bad;
  exp_t sb[$];
  vec_t vecs[18];

  ppe_w1024_p dut (
    .clk        (clk),
    .rst        (rst),
    .Req        (Req),
    .P_enc      (P_enc),
    .o_value    (o_value),
    .o_value_inc(o_value_inc),
    .valid      (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk the priority order explicitly, starting at p and wrapping.
  function automatic logic [10:0] model(input logic [1023:0] r, input logic [9:0] p);
    logic [9:0] idx;
    for (int k = 0; k < 1024; k++) begin
      idx = p + 10'(k);
      if (r[idx]) return {1'b1, idx};
    end
    return 11'd0;
  endfunction

  task automatic checkOutput(input string name, input logic [9:0] ev, input logic [9:0] ei,
                             input logic evld);
    total++;
    if (o_value !== ev || o_value_inc !== ei || valid !== evld) begin
      bad++;
      $display("[TB] FAIL %s: got value=%0d inc=%0d valid=%0b, want value=%0d inc=%0d valid=%0b",
               name, o_value, o_value_inc, valid, ev, ei, evld);
    end
  endtask

  // Drives one sample, queues its expectation, and checks the result due two edges later.
  task automatic applyStimulus(input logic [1023:0] r, input logic [9:0] p, input logic [9:0] ev,
                               input logic [9:0] ei, input logic evld, input int tag);
    exp_t e;
    Req   = r;
    P_enc = p;
    e.ev = ev; e.ei = ei; e.evld = evld; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      checkOutput($sformatf("vec%0d", e.tag), e.ev, e.ei, e.evld);
    end
  endtask

  task automatic applyModel(input logic [1023:0] r, input logic [9:0] p, input int tag);
    logic [10:0] m;
    m = model(r, p);
    applyStimulus(r, p, m[9:0], m[10] ? m[9:0] + 10'd1 : 10'd0, m[10], tag);
  endtask

  initial begin
    logic [1023:0] r;
    logic [1023:0] ones;
    logic [9:0]    p;

    total = 0;
    bad   = 0;
    ones  = {1024{1'b1}};

    vecs[0]  = '{1024'b0100101001, 10'd5, 10'd5, 10'd6, 1'b1};
    vecs[1]  = '{1024'b0100101001, 10'd4, 10'd5, 10'd6, 1'b1};
    vecs[2]  = '{1024'b0100101001, 10'd3, 10'd3, 10'd4, 1'b1};
    vecs[3]  = '{1024'b0100101001, 10'd1, 10'd3, 10'd4, 1'b1};
    vecs[4]  = '{1024'b0100101001, 10'd0, 10'd0, 10'd1, 1'b1};
    vecs[5]  = '{1024'b0100101001, 10'd6, 10'd8, 10'd9, 1'b1};
    vecs[6]  = '{1024'b1100101001, 10'd1, 10'd3, 10'd4, 1'b1};
    vecs[7]  = '{1024'b1010101001, 10'd0, 10'd0, 10'd1, 1'b1};
    vecs[8]  = '{1024'b0100111001, 10'd2, 10'd3, 10'd4, 1'b1};
    vecs[9]  = '{1024'b0100101001, 10'd9, 10'd0, 10'd1, 1'b1};
    vecs[10] = '{1024'd1 << 1023, 10'd1023, 10'd1023, 10'd0, 1'b1};
    vecs[11] = '{1024'd1 << 2, 10'd700, 10'd2, 10'd3, 1'b1};
    vecs[12] = '{ones, 10'd500, 10'd500, 10'd501, 1'b1};
    vecs[13] = '{ones, 10'd501, 10'd501, 10'd502, 1'b1};
    vecs[14] = '{ones, 10'd502, 10'd502, 10'd503, 1'b1};
    vecs[15] = '{ones, 10'd503, 10'd503, 10'd504, 1'b1};
    vecs[16] = '{ones, 10'd511, 10'd511, 10'd512, 1'b1};
    vecs[17] = '{1024'd0, 10'd4, 10'd0, 10'd0, 1'b0};

    rst   = 1'b0;
    Req   = '0;
    P_enc = '0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("reset%0d", c), 10'd0, 10'd0, 1'b0);
    end

    rst = 1'b1;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].req, vecs[i].p, vecs[i].ev, vecs[i].ei, vecs[i].evld, i);
    end

    // Reset while a valid sample sits in each stage.
    applyStimulus(1024'b1000, 10'd0, 10'd3, 10'd4, 1'b1, 100);
    applyStimulus(1024'b10000, 10'd0, 10'd4, 10'd5, 1'b1, 101);
    Req   = 1024'b100000;
    P_enc = 10'd0;
    rst   = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_edge", 10'd0, 10'd0, 1'b0);
    sb.delete();
    rst = 1'b1;
    applyStimulus(1024'b1000000, 10'd0, 10'd6, 10'd7, 1'b1, 102);
    checkOutput("no_stale", 10'd0, 10'd0, 1'b0);
    applyStimulus(1024'd1 << 1023, 10'd1023, 10'd1023, 10'd0, 1'b1, 103);

    // Random traffic against the reference model: sparse, wrap-prone and empty vectors.
    for (int n = 0; n < 60; n++) begin
      r = '0;
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
        p = 10'($urandom_range(0, 1023));
        r[p] = 1'b1;
      end
      p = 10'($urandom_range(0, 1023));
      applyModel(r, p, 200 + n);
    end

    applyStimulus('0, 10'd0, 10'd0, 10'd0, 1'b0, 300);
    applyStimulus('0, 10'd0, 10'd0, 10'd0, 1'b0, 301);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
